// File: rtl/bcd_to_7seg_if.sv
// Digit-in / segment-out bundle for one seven-segment decoder stage.
// The master drives the BCD digit; the slave (decoder) drives the cathode pattern.
interface bcd_to_7seg_if;
    logic [3:0] Q;
    logic [7:0] cathode;

    modport master (
        output Q,
        input  cathode
    );

    modport slave (
        input  Q,
        output cathode
    );
endinterface

// File: rtl/bcd_to_7seg.sv
// Registered BCD to seven-segment decoder; bit map {dp, g, f, e, d, c, b, a}.
// Codes 10-15 and unknown inputs blank the digit; the decimal point is never lit.
module bcd_to_7seg #(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    bcd_to_7seg_if.slave  bus
);

    localparam logic [7:0] Blank = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [7:0] lit;
    logic [7:0] cathode_d;
    logic [7:0] cathode_q;

    always_comb begin
        lit = 8'h00;
        case (bus.Q)
            4'd0:    lit = 8'h3F;
            4'd1:    lit = 8'h06;
            4'd2:    lit = 8'h5B;
            4'd3:    lit = 8'h4F;
            4'd4:    lit = 8'h66;
            4'd5:    lit = 8'h6D;
            4'd6:    lit = 8'h7D;
            4'd7:    lit = 8'h07;
            4'd8:    lit = 8'h7F;
            4'd9:    lit = 8'h6F;
            default: lit = 8'h00;
        endcase
        cathode_d = SEG_ACTIVE_LOW ? ~lit : lit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cathode_q <= Blank;
        end else begin
            cathode_q <= cathode_d;
        end
    end

    assign bus.cathode = cathode_q;

endmodule

// File: tb/tb_bcd_to_7seg.sv
// Directed bench for bcd_to_7seg: one active-low and one active-high instance.
module tb_bcd_to_7seg;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    bcd_to_7seg_if bus_lo ();
    bcd_to_7seg_if bus_hi ();

    bcd_to_7seg #(.SEG_ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_lo)
    );

    bcd_to_7seg #(.SEG_ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    logic [7:0] exp_lo [10];

    initial begin
        exp_lo = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        bus_lo.Q  = 4'd8;
        bus_hi.Q  = 4'd8;

        // Reset held: blank immediately and on every edge.
        #1;
        check_eq("reset_hold_now", bus_lo.cathode, 8'hFF);
        repeat (3) begin
            @(posedge clk);
            #1;
            check_eq("reset_hold_edge", bus_lo.cathode, 8'hFF);
        end

        @(negedge clk);
        reset = 1'b0;

        // Valid digit sweep.
        for (int i = 0; i < 10; i++) begin
            bus_lo.Q = 4'(i);
            @(posedge clk);
            #1;
            check_eq($sformatf("digit_%0d", i), bus_lo.cathode, exp_lo[i]);
            check_eq("dp_off_valid", {7'd0, bus_lo.cathode[7]}, 8'h01);
            repeat (4) @(posedge clk);
            #1;
            check_eq($sformatf("digit_%0d_hold", i), bus_lo.cathode, exp_lo[i]);
            @(negedge clk);
        end

        // Invalid codes blank.
        for (int i = 10; i < 16; i++) begin
            bus_lo.Q = 4'(i);
            @(posedge clk);
            #1;
            check_eq($sformatf("invalid_%0d", i), bus_lo.cathode, 8'hFF);
            check_eq("dp_off_invalid", {7'd0, bus_lo.cathode[7]}, 8'h01);
            @(negedge clk);
        end

        // One-cycle latency.
        bus_lo.Q = 4'd1;
        @(posedge clk);
        #1;
        check_eq("latency_edge_n", bus_lo.cathode, 8'hF9);
        bus_lo.Q = 4'd7;
        #3;
        check_eq("latency_before_n1", bus_lo.cathode, 8'hF9);
        @(posedge clk);
        #1;
        check_eq("latency_edge_n1", bus_lo.cathode, 8'hF8);

        // Mid-operation reset pulse between edges.
        @(negedge clk);
        bus_lo.Q = 4'd0;
        @(posedge clk);
        #1;
        check_eq("pre_pulse", bus_lo.cathode, 8'hC0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("pulse_async", bus_lo.cathode, 8'hFF);
        #1;
        reset = 1'b0;
        #1;
        check_eq("pulse_released", bus_lo.cathode, 8'hFF);
        @(posedge clk);
        #1;
        check_eq("pulse_restore", bus_lo.cathode, 8'hC0);

        // Active-high polarity instance.
        @(negedge clk);
        bus_hi.Q = 4'd2;
        @(posedge clk);
        #1;
        check_eq("hi_digit_2", bus_hi.cathode, 8'h5B);
        @(negedge clk);
        bus_hi.Q = 4'd12;
        @(posedge clk);
        #1;
        check_eq("hi_invalid_12", bus_hi.cathode, 8'h00);
        @(negedge clk);
        bus_hi.Q = 4'd8;
        @(posedge clk);
        #1;
        check_eq("hi_digit_8", bus_hi.cathode, 8'h7F);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("hi_reset", bus_hi.cathode, 8'h00);
        check_eq("lo_reset", bus_lo.cathode, 8'hFF);
        @(negedge clk);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
